trig_in_conditioner: RTL and testbench

- Upstream conditioning stage for the 16 coax trigger inputs arriving from the other boards.
- Per channel: resynchronises to clk_adc, detects rising edges, enforces a programmable holdoff (dead time), applies a programmable 0..7-tick deskew delay and emits one-cycle trigger pulses.
- The downstream trigger/histogram stage consumes these pulses as its coax_in.
- Also keeps gated per-channel rate counters for slow-control readback.

---
 rtl/trig_pkg.sv | 12 +
 rtl/trig_chan_cond.sv | 44 ++++
 rtl/trig_in_conditioner.sv | 46 ++++
 tb/tb_trig_in_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// trig_pkg: shared widths, types and saturating add for the trigger input conditioner
package trig_pkg;
    localparam int NCH    = 16;
    localparam int DLY_W  = 3;
    localparam int HOLD_W = 8;
    localparam int DEPTH  = 1 << DLY_W;
    typedef logic [DLY_W-1:0] dly_t;
    typedef logic [31:0] rate_t;
    function automatic rate_t sat_add(input rate_t a, input logic b);
        return (b && a != '1) ? a + 32'd1 : a;
    endfunction
endpackage

// File: rtl/trig_chan_cond.sv
// trig_chan_cond: sync, edge detect, holdoff, deskew delay and gated rate count for one channel
module trig_chan_cond
    import trig_pkg::*;
(
    input  logic              clk_adc,
    input  logic              rst,
    input  logic              coax,
    input  logic              en,
    input  logic [DLY_W-1:0]  dly,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic              wrap,
    output logic              trig,
    output logic [31:0]       snap
);
    logic [2:0] s;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DEPTH-1:0] dl;
    dly_t tap;
    rate_t cnt;
    logic rise, acc;
    always_comb begin
        tap = dly;
        rise = s[1] & ~s[2];
        acc = rise & en & (hold_cnt == '0);
    end
    // holdoff gates the edge before the delay line, so dead time is in input time
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            s <= '0;
            hold_cnt <= '0;
            dl <= '0;
            trig <= 1'b0;
            cnt <= '0;
            snap <= '0;
        end else begin
            s <= {s[1:0], coax};
            hold_cnt <= acc ? holdoff : (hold_cnt != '0 ? hold_cnt - 1'b1 : hold_cnt);
            dl <= {dl[DEPTH-2:0], acc};
            trig <= dl[tap];
            cnt <= wrap ? '0 : sat_add(cnt, acc);
            if (wrap) snap <= sat_add(cnt, acc);
        end
    end
endmodule

// File: rtl/trig_in_conditioner.sv
// trig_in_conditioner: per-channel coax trigger conditioning with gated rate readback
module trig_in_conditioner
    import trig_pkg::*;
#(
    parameter int GATE_LOG2 = 25
) (
    input  logic                   clk_adc,
    input  logic                   rst,
    input  logic [NCH-1:0]         coax_in,
    input  logic [NCH-1:0]         chan_mask,
    input  logic [NCH*DLY_W-1:0]   delay_set,
    input  logic [HOLD_W-1:0]      holdoff,
    input  logic [3:0]             rate_sel,
    output logic [NCH-1:0]         trig_out,
    output logic [31:0]            rate_out,
    output logic                   rate_valid
);
    logic [GATE_LOG2-1:0] gate;
    logic wrap;
    rate_t snap [NCH];
    assign wrap = &gate;
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        trig_chan_cond u_chan (
            .clk_adc (clk_adc),
            .rst     (rst),
            .coax    (coax_in[i]),
            .en      (chan_mask[i]),
            .dly     (delay_set[i*DLY_W +: DLY_W]),
            .holdoff (holdoff),
            .wrap    (wrap),
            .trig    (trig_out[i]),
            .snap    (snap[i])
        );
    end
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            gate <= '0;
            rate_valid <= 1'b0;
            rate_out <= '0;
        end else begin
            gate <= gate + 1'b1;
            rate_valid <= wrap;
            rate_out <= snap[rate_sel];
        end
    end
endmodule

// File: tb/tb_trig_in_conditioner.sv
// tb_trig_in_conditioner: scoreboard bench, expected trigger times queued at stimulus time
module tb_trig_in_conditioner;
    import trig_pkg::*;
    localparam int GL = 6;
    logic clk_adc = 1'b0;
    logic rst = 1'b1;
    logic [NCH-1:0] coax_in = '0;
    logic [NCH-1:0] chan_mask = '1;
    logic [NCH*DLY_W-1:0] delay_set = '0;
    logic [HOLD_W-1:0] holdoff = '0;
    logic [3:0] rate_sel = '0;
    logic [NCH-1:0] trig_out;
    logic [31:0] rate_out;
    logic rate_valid;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int gate_e = 0;
    typedef struct {int t; int ch;} ev_t;
    ev_t sb[$];

    trig_in_conditioner #(.GATE_LOG2(GL)) dut (
        .clk_adc    (clk_adc),
        .rst        (rst),
        .coax_in    (coax_in),
        .chan_mask  (chan_mask),
        .delay_set  (delay_set),
        .holdoff    (holdoff),
        .rate_sel   (rate_sel),
        .trig_out   (trig_out),
        .rate_out   (rate_out),
        .rate_valid (rate_valid)
    );

    always #5 clk_adc = ~clk_adc;
    always @(posedge clk_adc) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // every cycle outside reset, trig_out must equal exactly the pulses due now
    always @(negedge clk_adc) begin
        logic [NCH-1:0] ev;
        ev = '0;
        if (!rst) begin
            for (int j = sb.size() - 1; j >= 0; j--)
                if (sb[j].t == cyc) begin
                    ev[sb[j].ch] = 1'b1;
                    sb.delete(j);
                end
            check("trig_out", 32'(trig_out), 32'(ev));
        end
    end

    task automatic go_to(input int k);
        while (cyc < k) begin
            @(posedge clk_adc);
            #1;
        end
    endtask

    task automatic pulse(input int ch, input int k, input bit fire);
        go_to(k);
        coax_in[ch] = 1'b1;
        if (fire) sb.push_back('{k + 4 + int'(delay_set[ch*DLY_W +: DLY_W]), ch});
        go_to(k + 1);
        coax_in[ch] = 1'b0;
    endtask

    task automatic wait_gate();
        int n;
        n = 0;
        while (rate_valid !== 1'b1 && n < 200) begin
            @(negedge clk_adc);
            n++;
        end
        check("gate_found", 32'(n < 200), 32'd1);
        gate_e = cyc;
        @(negedge clk_adc);
        check("rate_valid_width", 32'(rate_valid), 32'd0);
    endtask

    task automatic read_rate(input int ch, input logic [31:0] exp, input string tag);
        @(posedge clk_adc);
        #1 rate_sel = 4'(ch);
        @(posedge clk_adc);
        #1 check(tag, rate_out, exp);
    endtask

    initial begin
        int k;
        int e0;
        repeat (3) @(posedge clk_adc);
        #1;
        check("rst_trig", 32'(trig_out), 32'd0);
        check("rst_rate_out", rate_out, 32'd0);
        check("rst_rate_valid", 32'(rate_valid), 32'd0);
        rst = 1'b0;

        pulse(3, cyc + 2, 1'b1);
        go_to(cyc + 10);

        for (int d = 0; d < 8; d++) begin
            delay_set[5*DLY_W +: DLY_W] = 3'(d);
            pulse(5, cyc + 1, 1'b1);
            go_to(cyc + 14);
        end

        for (int i = 0; i < NCH; i++) delay_set[i*DLY_W +: DLY_W] = 3'(i % 8);
        go_to(cyc + 1);
        k = cyc;
        coax_in = '1;
        for (int i = 0; i < NCH; i++) sb.push_back('{k + 4 + (i % 8), i});
        go_to(k + 1);
        coax_in = '0;
        go_to(cyc + 14);
        delay_set = '0;

        holdoff = 8'd10;
        wait_gate();
        e0 = gate_e;
        pulse(0, e0 + 2, 1'b1);
        pulse(0, e0 + 7, 1'b0);
        pulse(0, e0 + 14, 1'b1);
        wait_gate();
        read_rate(0, 32'd2, "rate_holdoff");
        holdoff = '0;

        chan_mask[7] = 1'b0;
        wait_gate();
        e0 = gate_e;
        for (int i = 0; i < 20; i++) begin
            pulse(7, e0 + 2 + 2*i, 1'b0);
            if (i < 5) pulse(6, e0 + 3 + 2*i, 1'b1);
        end
        wait_gate();
        read_rate(7, 32'd0, "rate_masked");
        read_rate(6, 32'd5, "rate_neighbour");
        chan_mask[7] = 1'b1;

        wait_gate();
        e0 = gate_e;
        for (int i = 0; i < 8; i++) pulse(2, e0 + 2 + 2*i, 1'b1);
        pulse(2, e0 + 61, 1'b1);
        wait_gate();
        check("gate_period", 32'(gate_e - e0), 32'd64);
        read_rate(2, 32'd9, "rate_gate");
        wait_gate();
        read_rate(2, 32'd0, "rate_next_gate");

        delay_set[1*DLY_W +: DLY_W] = 3'd7;
        go_to(cyc + 1);
        k = cyc;
        pulse(1, k, 1'b0);
        go_to(k + 4);
        rst = 1'b1;
        go_to(k + 5);
        rst = 1'b0;
        check("post_rst_trig", 32'(trig_out), 32'd0);
        check("post_rst_rate_out", rate_out, 32'd0);
        check("post_rst_rate_valid", 32'(rate_valid), 32'd0);
        go_to(k + 20);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
